// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if
// CPU-side bus of the interrupt sequencer.
//   INTA     : acknowledge strobe from the CPU, active low, asynchronous
//   INT      : interrupt request to the CPU
//   data_out : vector byte
//   data_oe  : enable for driving data_out onto the CPU bus
// master = CPU side, slave = sequencer side.
interface interrupt_sequencer_if;
    logic       INTA;
    logic       INT;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (output INTA, input INT, data_out, data_oe);
    modport slave  (input INTA, output INT, data_out, data_oe);
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Priority resolution, INT/INTA sequencing, in-service register and rotating
// priority for the programmable interrupt controller.
//   clk, reset        : system clock, synchronous active-high reset
//   bus (slave)       : INTA in, INT / data_out / data_oe out
//   irr, imr          : pending requests and mask (1 = masked)
//   number_of_ack     : 1 = single INTA pulse, anything else = two pulses
//   aeoi, rotate_on_aeoi : automatic EOI at end of vector pulse, optional rotate
//   vector_base       : vector bits [7:3]
//   eoi_cmd/specific/rotate/level : EOI command strobe and its options
//   reset_irr_bit, irr_highest_bit : clear request for the acknowledged irr bit
//   isr               : in-service register
module interrupt_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_sequencer_if.slave  bus,
    input  logic [7:0]            irr,
    input  logic [7:0]            imr,
    input  logic [1:0]            number_of_ack,
    input  logic                  aeoi,
    input  logic                  rotate_on_aeoi,
    input  logic [4:0]            vector_base,
    input  logic                  eoi_cmd,
    input  logic                  eoi_specific,
    input  logic                  eoi_rotate,
    input  logic [2:0]            eoi_level,
    output logic                  reset_irr_bit,
    output logic [7:0]            irr_highest_bit,
    output logic [7:0]            isr
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACK1   = 2'd1;
    localparam logic [1:0] VECTOR = 2'd2;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   inta_d;
    logic [2:0]             lowest_prio;
    logic [2:0]             ack_level;
    logic                   spurious;
    logic                   seen_rise;

    logic       inta_s, fall, rise;
    logic [7:0] cand;
    logic       win_ok, isr_ok, pending;
    logic [2:0] win_lvl, win_rank, isr_lvl, isr_rank, sel_lvl;
    logic [7:0] set_mask, clr_mask, isr_next;
    logic       rot_en;
    logic [2:0] rot_lvl;

    assign inta_s = sync[SYNC_STAGES-1];
    assign fall   = inta_d & ~inta_s;
    assign rise   = ~inta_d & inta_s;
    assign cand   = irr & ~imr;

    // Scan from lowest to highest priority so the last hit is the winner.
    // rank 0 is the highest priority level (lowest_prio + 1).
    always_comb begin
        logic [2:0] idx;
        idx      = 3'd0;
        win_ok   = 1'b0;
        win_lvl  = 3'd0;
        win_rank = 3'd0;
        isr_ok   = 1'b0;
        isr_lvl  = 3'd0;
        isr_rank = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = 3'(lowest_prio + 3'(k) + 3'd1);
            if (cand[idx]) begin
                win_ok   = 1'b1;
                win_lvl  = idx;
                win_rank = 3'(k);
            end
            if (isr[idx]) begin
                isr_ok   = 1'b1;
                isr_lvl  = idx;
                isr_rank = 3'(k);
            end
        end
    end

    // Fully nested: only strictly higher priority than anything in service.
    assign pending = win_ok && (!isr_ok || (win_rank < isr_rank));
    assign sel_lvl = pending ? win_lvl : 3'd7;

    // isr set/clear sources; set is applied last so it wins on the same bit.
    always_comb begin
        set_mask = 8'd0;
        clr_mask = 8'd0;
        rot_en   = 1'b0;
        rot_lvl  = lowest_prio;
        if (state == IDLE && fall && pending)
            set_mask[win_lvl] = 1'b1;
        if (state == VECTOR && rise && aeoi && !spurious) begin
            clr_mask[ack_level] = 1'b1;
            if (rotate_on_aeoi) begin
                rot_en  = 1'b1;
                rot_lvl = ack_level;
            end
        end
        if (eoi_cmd) begin
            if (eoi_specific) begin
                clr_mask[eoi_level] = 1'b1;
                if (eoi_rotate) begin
                    rot_en  = 1'b1;
                    rot_lvl = eoi_level;
                end
            end else if (isr_ok) begin
                // non-specific EOI with nothing in service does nothing
                clr_mask[isr_lvl] = 1'b1;
                if (eoi_rotate) begin
                    rot_en  = 1'b1;
                    rot_lvl = isr_lvl;
                end
            end
        end
        isr_next = (isr & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            sync            <= '1;
            inta_d          <= 1'b1;
            lowest_prio     <= 3'd7;
            ack_level       <= 3'd0;
            spurious        <= 1'b0;
            seen_rise       <= 1'b0;
            isr             <= 8'd0;
            reset_irr_bit   <= 1'b0;
            irr_highest_bit <= 8'd0;
            bus.INT         <= 1'b0;
            bus.data_out    <= 8'd0;
            bus.data_oe     <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], bus.INTA};
            inta_d        <= inta_s;
            isr           <= isr_next;
            reset_irr_bit <= 1'b0;
            if (rot_en)
                lowest_prio <= rot_lvl;
            case (state)
                IDLE: begin
                    bus.INT     <= pending;
                    bus.data_oe <= 1'b0;
                    if (fall) begin
                        bus.INT         <= 1'b0;
                        spurious        <= !pending;
                        ack_level       <= sel_lvl;
                        irr_highest_bit <= pending ? (8'd1 << win_lvl) : 8'd0;
                        reset_irr_bit   <= pending;
                        bus.data_out    <= {vector_base, sel_lvl};
                        if (number_of_ack == 2'd1) begin
                            // single-pulse mode: this pulse carries the vector
                            state       <= VECTOR;
                            bus.data_oe <= 1'b1;
                        end else begin
                            state     <= ACK1;
                            seen_rise <= 1'b0;
                        end
                    end
                end
                ACK1: begin
                    bus.INT      <= 1'b0;
                    bus.data_oe  <= 1'b0;
                    bus.data_out <= {vector_base, ack_level};
                    if (rise)
                        seen_rise <= 1'b1;
                    if (seen_rise && fall) begin
                        state       <= VECTOR;
                        bus.data_oe <= 1'b1;
                    end
                end
                VECTOR: begin
                    bus.INT      <= 1'b0;
                    bus.data_out <= {vector_base, ack_level};
                    if (rise) begin
                        bus.data_oe <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.INT     <= 1'b0;
                    bus.data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Synchronous control block that sits between the interrupt request register (`irr`) and the CPU bus interface of the programmable interrupt controller. It resolves priority among pending unmasked requests, raises `INT`, and sequences the CPU acknowledge pulses on `INTA`. It also maintains the in-service register and the rotating priority pointer, drives the vector byte, and produces the `reset_irr_bit` / `irr_highest_bit` pair that clears the acknowledged request in `irr`.

## Interface
Parameters:
- `SYNC_STAGES`, 2, flip-flop stages synchronising `INTA` into `clk`; legal values are 2 and 3.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `INTA`  in  1  CPU acknowledge strobe, active low, asynchronous to `clk`.
- `irr`  in  8  pending requests.
- `imr`  in  8  mask; 1 = masked.
- `number_of_ack`  in  2  `INTA` pulses per acknowledge cycle: 1 = single pulse; 2, 0 and 3 are all treated as 2.
- `aeoi`  in  1  automatic end-of-interrupt mode.
- `rotate_on_aeoi`  in  1  rotate priority when an automatic EOI occurs.
- `vector_base`  in  5  vector bits [7:3].
- `eoi_cmd`  in  1  one-cycle EOI command strobe.
- `eoi_specific`  in  1  1 = specific EOI on `eoi_level`; 0 = non-specific EOI.
- `eoi_rotate`  in  1  rotate priority with this EOI.
- `eoi_level`  in  3  level used by a specific EOI.
- `INT`  out  1  interrupt request to the CPU.
- `reset_irr_bit`  out  1  one-cycle pulse that clears the `irr` bit selected by `irr_highest_bit`.
- `irr_highest_bit`  out  8  one-hot acknowledged level, or 0.
- `isr`  out  8  in-service register.
- `data_out`  out  8  vector byte.
- `data_oe`  out  1  enable for driving `data_out`.

## Operation
- **Candidate set:** `cand = irr & ~imr`.
- **Priority order:** starts at `(lowest_prio+1) mod 8` and wraps upward; `lowest_prio` resets to 7, which gives IR0 the highest priority.
- **Winner:** the first set bit of `cand` in priority order.
- **Fully nested rule:** `pending` = the winner exists AND has strictly higher priority than the highest-priority set `isr` bit, or `isr` is all zero.
- **IDLE:**
  - `INT` is registered `pending`.
  - On a synchronised `INTA` falling edge with `pending`: latch the winner as `ack_level`, set `isr[ack_level]`, drive `irr_highest_bit` one-hot and pulse `reset_irr_bit`.
  - On the same edge without `pending` (spurious): `ack_level` = 7, `isr` unchanged, no `reset_irr_bit` pulse, `irr_highest_bit` = 0.
  - Next state is VECTOR when `number_of_ack` = 1, otherwise ACK1.
- **ACK1:** `INT` = 0, `data_oe` = 0. Wait for the `INTA` rising edge followed by the next falling edge, then go to VECTOR.
- **VECTOR:**
  - `data_out = {vector_base, ack_level}`; `data_oe` = 1 while the synchronised `INTA` is low.
  - On the `INTA` rising edge:
    - if `aeoi` and not spurious: clear `isr[ack_level]`; if `rotate_on_aeoi` also, set `lowest_prio = ack_level`.
    - return to IDLE.
- **EOI (`eoi_cmd` = 1), accepted in any state:**
  - The target level is `eoi_level` when `eoi_specific`, otherwise the highest-priority set `isr` bit.
  - Clear `isr` at the target level; if `eoi_rotate`, set `lowest_prio` to the target level.
  - A non-specific EOI with `isr` = 0 is a no-op, including no rotation.
- **Simultaneous set and clear of `isr`:** a set and a clear in the same cycle on different bits both apply. On the same bit, the set wins.
- **Reset:** `INT` = 0, `reset_irr_bit` = 0, `irr_highest_bit` = 0, `isr` = 0, `data_out` = 0, `data_oe` = 0, `lowest_prio` = 7, state = IDLE, synchroniser cleared to 1 (idle high). Reset during ACK1 or VECTOR aborts the cycle immediately.

## Timing
- `INTA` edges are detected `SYNC_STAGES`+1 cycles after the pin changes. The CPU must hold each pulse level for at least `SYNC_STAGES`+2 cycles.
- `INT` rises 1 cycle after `cand`, `imr` or `isr` makes `pending` true, and falls 1 cycle after the first-pulse edge is detected.
- `reset_irr_bit` is high for exactly 1 cycle, the cycle after first-pulse edge detection. `irr_highest_bit` holds its value until the next acknowledge or reset.
- `isr` updates in that same cycle, so `isr` and `reset_irr_bit` change together.
- `data_oe` rises 1 cycle after detection of the vector pulse's falling edge and falls 1 cycle after detection of its rising edge.
- An EOI takes effect on `isr` 1 cycle after `eoi_cmd`. `INT` re-evaluates in the following cycle.
- Changes to `irr` after the winner is latched do not affect `ack_level`.

## Test plan
- Reset, `irr`=0x24, `imr`=0, 2-pulse `INTA`, `vector_base`=0x08 -> `INT`=1; after pulse 1 `isr`=0x04, `reset_irr_bit` pulses once, `irr_highest_bit`=0x04; pulse 2 drives `data_out`=0x42 with `data_oe`=1.
- `isr`=0x04, `irr` raises bit 1 then bit 5 -> `INT`=1 only for bit 1; non-specific EOI clears `isr` to 0x00, after which bit 5 asserts `INT`.
- `aeoi`=1, `rotate_on_aeoi`=1, `irr`=0x01, 1-pulse mode -> `isr` returns to 0 at pulse end; with `irr`=0x81 next, the winner is IR7 (0x80).
- `irr` drops to 0 between `INT` and pulse 1 -> spurious: `isr` unchanged, no `reset_irr_bit`, vector = `{vector_base, 3'b111}`.
- `eoi_cmd` with `eoi_specific`=1, `eoi_level`=3, `isr`=0x0A -> `isr`=0x02; an EOI in the same cycle that sets bit 3 -> bit 3 stays set.
- `reset` asserted mid-VECTOR -> next cycle `data_oe`=0, `isr`=0, `INT`=0, IDLE; a new request is then acknowledged with `lowest_prio`=7.
